// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcode classes and mux selects for multi_cycle_ctrl
package ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_IMM    = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  function automatic logic is_legal(input logic [6:0] op);
    return op[1:0] == 2'b11 && (op[6:2] inside {OP_R, OP_I, OP_LOAD, OP_JALR, OP_STORE,
                                                OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL});
  endfunction
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive waiting cycles, flags expiry on the last allowed one
// ports: clk, rst_n (async, active low), clear (state change), waiting (ready low),
//        expired (waiting in cycle TIMEOUT_CYCLES of the wait)
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  assign expired = waiting && cnt == W'(TIMEOUT_CYCLES - 1);
  // expiry restarts the count so a retried fetch gets a full new window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || expired || !waiting) ? '0 : cnt + W'(1);
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB controller for a multi-cycle RV32 core
// ports: clk, rst_n (async, active low); opcode (IR[6:0]), branch_taken, imem_ready,
//        dmem_ready in; imem_req, ir_we, imm_we, pc_we, pc_sel, dmem_req, dmem_we,
//        rf_we, wb_sel, mem_timeout, illegal_inst, state out.
// CTRL_TRAP_EN: illegal opcodes enter TRAP (sticky until reset) instead of running as NOP.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       imm_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       mem_timeout,
  output logic       illegal_inst,
  output logic [2:0] state
);
  state_t cur, nxt;
  logic [4:0] op_q;
  logic nop_q;
  logic waiting, expired;
  assign state = cur;
  assign waiting = (cur == FETCH && !imem_ready) || (cur == MEM && !dmem_ready);
  assign mem_timeout = expired;
`ifdef CTRL_TRAP_EN
  assign illegal_inst = cur == TRAP;
`else
  assign illegal_inst = 1'b0;
`endif
  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(nxt != cur),
    .waiting(waiting),
    .expired(expired)
  );
  // the opcode class is captured in DECODE so later states decode from registers only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur   <= FETCH;
      op_q  <= '0;
      nop_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) begin
        op_q  <= opcode[6:2];
        nop_q <= !is_legal(opcode);
      end
    end
  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    imm_we   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    case (cur)
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        nxt      = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        imm_we = 1'b1;
`ifdef CTRL_TRAP_EN
        nxt = is_legal(opcode) ? EXEC : TRAP;
`else
        nxt = EXEC;
`endif
      end
      EXEC: begin
        if (!nop_q && op_q == OP_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
        end
        nxt = nop_q ? WB :
              (op_q == OP_LOAD || op_q == OP_STORE) ? MEM :
              op_q == OP_BRANCH ? FETCH : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op_q == OP_STORE;
        pc_we    = dmem_ready && op_q == OP_STORE;
        // ready beats an expiring timer; on expiry the instruction is refetched
        nxt = dmem_ready ? (op_q == OP_STORE ? FETCH : WB) : expired ? FETCH : MEM;
      end
      WB: begin
        rf_we  = !nop_q;
        pc_we  = 1'b1;
        wb_sel = nop_q ? WB_ALU : op_q == OP_LOAD ? WB_MEM :
                 (op_q == OP_JAL || op_q == OP_JALR) ? WB_PC4 : WB_ALU;
        pc_sel = nop_q ? PC_PLUS4 : op_q == OP_JAL ? PC_IMM :
                 op_q == OP_JALR ? PC_ALU : PC_PLUS4;
        nxt    = FETCH;
      end
`ifdef CTRL_TRAP_EN
      TRAP: nxt = TRAP;
`endif
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed cycle-by-cycle checks of multi_cycle_ctrl outputs
module tb_multi_cycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] opcode = 7'h33;
  logic branch_taken = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic imem_req, ir_we, imm_we, pc_we, dmem_req, dmem_we, rf_we, mem_timeout, illegal_inst;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
  logic [15:0] outv;
  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_we(ir_we), .imm_we(imm_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .mem_timeout(mem_timeout), .illegal_inst(illegal_inst), .state(state)
  );

  always #5 clk = ~clk;

  assign outv = {imem_req, ir_we, imm_we, pc_we, pc_sel, dmem_req, dmem_we, rf_we, wb_sel,
                 mem_timeout, illegal_inst, state};

  function automatic logic [15:0] ev(int st, int ireq, int irw, int imw, int pcw, int pcs,
                                     int dreq, int dwe, int rfw, int wbs, int mto, int ill);
    return {1'(ireq), 1'(irw), 1'(imw), 1'(pcw), 2'(pcs), 1'(dreq), 1'(dwe), 1'(rfw),
            2'(wbs), 1'(mto), 1'(ill), 3'(st)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (outv !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset got %b exp %b", outv, ev(0,1,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [15:0] e[5];
    logic im[5];
    do_reset();
    opcode = 7'h33;
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(4,0,0,0,1,0,0,0,1,0,0,0),
          ev(0,1,0,0,0,0,0,0,0,0,0,0)};
    im = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      imem_ready = im[i];
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL rtype cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load();
    logic [15:0] e[8];
    logic dm[8];
    do_reset();
    opcode = 7'h03;
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(3,0,0,0,0,0,1,0,0,0,0,0),
          ev(3,0,0,0,0,0,1,0,0,0,0,0), ev(3,0,0,0,0,0,1,0,0,0,0,0),
          ev(4,0,0,0,1,0,0,0,1,1,0,0), ev(0,1,0,0,0,0,0,0,0,0,0,0)};
    dm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      imem_ready = i == 0;
      dmem_ready = dm[i];
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL load cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store();
    logic [15:0] e[5];
    do_reset();
    opcode = 7'h23;
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(3,0,0,0,1,0,1,1,0,0,0,0),
          ev(0,1,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      imem_ready = i == 0;
      dmem_ready = i == 3;
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL store cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    logic [15:0] e[7];
    do_reset();
    opcode = 7'h63;
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,1,1,0,0,0,0,0,0), ev(0,1,1,0,0,0,0,0,0,0,0,0),
          ev(1,0,0,1,0,0,0,0,0,0,0,0), ev(2,0,0,0,1,0,0,0,0,0,0,0),
          ev(0,1,0,0,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      imem_ready = i == 0 || i == 3;
      branch_taken = i == 2;
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL branch cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e[17];
    logic [6:0] op[4];
    logic [15:0] w[4];
    op = '{7'h6F, 7'h67, 7'h13, 7'h37};
    w = '{ev(4,0,0,0,1,1,0,0,1,2,0,0), ev(4,0,0,0,1,2,0,0,1,2,0,0),
          ev(4,0,0,0,1,0,0,0,1,0,0,0), ev(4,0,0,0,1,0,0,0,1,0,0,0)};
    for (int k = 0; k < 4; k++) begin
      e[4*k]   = ev(0,1,1,0,0,0,0,0,0,0,0,0);
      e[4*k+1] = ev(1,0,0,1,0,0,0,0,0,0,0,0);
      e[4*k+2] = ev(2,0,0,0,0,0,0,0,0,0,0,0);
      e[4*k+3] = w[k];
    end
    e[16] = ev(0,1,0,0,0,0,0,0,0,0,0,0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      imem_ready = i % 4 == 0 && i < 16;
      opcode = op[(i < 16 ? i : 15) / 4];
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL b2b cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] e;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      e = ev(0,1,0,0,0,0,0,0,0,0,(i == 15 || i == 31) ? 1 : 0,0);
      #3;
      checks++;
      if (outv !== e) begin
        errors++;
        $display("FAIL fetch_timeout cyc %0d got %b exp %b", i, outv, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ready_wins();
    logic [15:0] e;
    do_reset();
    opcode = 7'h33;
    for (int i = 0; i < 17; i++) begin
      imem_ready = i == 15;
      e = i == 16 ? ev(1,0,0,1,0,0,0,0,0,0,0,0) :
          i == 15 ? ev(0,1,1,0,0,0,0,0,0,0,0,0) : ev(0,1,0,0,0,0,0,0,0,0,0,0);
      #3;
      checks++;
      if (outv !== e) begin
        errors++;
        $display("FAIL ready_wins cyc %0d got %b exp %b", i, outv, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_timeout();
    logic [15:0] e;
    do_reset();
    opcode = 7'h23;
    for (int i = 0; i < 20; i++) begin
      imem_ready = i == 0;
      e = i == 0 ? ev(0,1,1,0,0,0,0,0,0,0,0,0) :
          i == 1 ? ev(1,0,0,1,0,0,0,0,0,0,0,0) :
          i == 2 ? ev(2,0,0,0,0,0,0,0,0,0,0,0) :
          i == 19 ? ev(0,1,0,0,0,0,0,0,0,0,0,0) :
          ev(3,0,0,0,0,0,1,1,0,0,i == 18 ? 1 : 0,0);
      #3;
      checks++;
      if (outv !== e) begin
        errors++;
        $display("FAIL mem_timeout cyc %0d got %b exp %b", i, outv, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    logic [15:0] e[6];
    do_reset();
    opcode = 7'h7F;
`ifdef CTRL_TRAP_EN
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(5,0,0,0,0,0,0,0,0,0,0,1), ev(5,0,0,0,0,0,0,0,0,0,0,1),
          ev(5,0,0,0,0,0,0,0,0,0,0,1), ev(5,0,0,0,0,0,0,0,0,0,0,1)};
`else
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(4,0,0,0,1,0,0,0,0,0,0,0),
          ev(0,1,0,0,0,0,0,0,0,0,0,0), ev(0,1,0,0,0,0,0,0,0,0,0,0)};
`endif
    for (int i = 0; i < 6; i++) begin
      imem_ready = i == 0;
      dmem_ready = i == 3;
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL illegal cyc %0d got %b exp %b", i, outv, e[i]);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (outv !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL illegal_reset got %b exp %b", outv, ev(0,1,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [15:0] e[4];
    do_reset();
    opcode = 7'h23;
    e = '{ev(0,1,1,0,0,0,0,0,0,0,0,0), ev(1,0,0,1,0,0,0,0,0,0,0,0),
          ev(2,0,0,0,0,0,0,0,0,0,0,0), ev(3,0,0,0,0,0,1,1,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      imem_ready = i == 0;
      #3;
      checks++;
      if (outv !== e[i]) begin
        errors++;
        $display("FAIL async_pre cyc %0d got %b exp %b", i, outv, e[i]);
      end
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outv !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", outv, ev(0,1,0,0,0,0,0,0,0,0,0,0));
    end
    dmem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    checks++;
    if (outv !== ev(0,1,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL async_after got %b exp %b", outv, ev(0,1,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk);
    #1 dmem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_fetch_timeout();
    test_ready_wins();
    test_mem_timeout();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
